dac_frame_receiver: RTL
=======================

// Module: dac_frame_receiver
// PURPOSE
//  Receiving end of the 3-wire DAC serial link (sclk, active-low sync, MSB-first data).
//  Synchronises the pins into clk, deserialises one FRAME_BITS frame per sync-low window,
//  and presents the word on a valid/ready handshake.
//  Used as the loopback checker for the DAC path and as the input stage for a
//  board-to-board serial link.
//  Link clock ser_clk must have high and low phases of >= 2 clk cycles each.
// PARAMETERS
//  FRAME_BITS   16  bits per frame; rx_word width
//  SYNC_STAGES  2   flops per input synchroniser (>=2)
// PORTS
//  clk        in   1           system clock, 100 MHz
//  rst        in   1           reset, asynchronous, active-high
//  ser_clk    in   1           link clock, asynchronous to clk
//  ser_sync   in   1           frame strobe, low during a frame, asynchronous
//  ser_data   in   1           serial data, MSB first, asynchronous
//  rx_word    out  FRAME_BITS  received word, stable while rx_valid=1
//  rx_valid   out  1           word available; held until accepted
//  rx_ready   in   1           consumer accepts word when rx_valid&rx_ready
//  frame_err  out  1           1-cycle pulse: sync rose with 0<bits<FRAME_BITS
//  overrun    out  1           sticky; set when a word is dropped; cleared only by rst
//  busy       out  1           high in state RX
// BEHAVIOUR
//  Reset values: rx_word=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=WAIT_IDLE.
//  Synchroniser flops for sync and sclk reset to 1 and 0 respectively.
//  Edge detection: clk_rise = synced sclk 0->1. sync_fall and sync_rise come from synced sync.
//  States:
//   WAIT_IDLE: go to IDLE when synced sync=1. A frame in progress at reset release is ignored.
//   IDLE: on sync_fall, go to RX with bit_cnt=0 and shift reg=0.
//   RX, each clk_rise: shift = {shift[FRAME_BITS-2:0], synced data}; bit_cnt++.
//   RX, on the clk_rise that makes bit_cnt==FRAME_BITS: deliver word; go to WAIT_IDLE.
//   RX, sync_rise before the last bit: frame_err pulse if bit_cnt>0; go to IDLE.
//     No pulse if bit_cnt==0 (empty frame, silently ignored).
//   Same cycle as clk_rise: sync_rise has priority. The bit is not taken; the frame is short.
//  Extra sclk edges after the last bit (still in WAIT_IDLE) are ignored with no error.
//  Delivery happens in the cycle after the completing clk_rise:
//   If rx_valid=0, or rx_valid&rx_ready this same cycle:
//     rx_word <= shift result; rx_valid <= 1.
//   Otherwise: the new word is dropped, overrun <= 1, and rx_word/rx_valid are unchanged.
//  Handshake: rx_valid falls the cycle after rx_valid&rx_ready, unless a new word loads then.
//   rx_word must not change while rx_valid=1 and rx_ready=0.
//  Latency: last sclk pin rise -> rx_valid high in SYNC_STAGES+2 clk cycles (4 at default).
//  bit_cnt width: $clog2(FRAME_BITS+1). It never wraps; it saturates at FRAME_BITS.
//  rst mid-frame: partial word discarded; rx_valid and overrun cleared.
// STRUCTURE
//  Package dac_serial_pkg:
//   DAC_FRAME_BITS=16 constant, shared with dac_controller.
//   Receiver state enum {WAIT_IDLE, IDLE, RX}.
//  Sub-module sync_edge_detect:
//   Params SYNC_STAGES and RESET_VAL.
//   Outputs level, rise and fall.
//   Instantiated three times; edge outputs of the data instance are unused.
//  Top level contains the FSM, bit counter, shift register and output register only.
// TESTING
//  Frame 0x00A5, sclk=8 clk periods -> rx_word=0x00A5, rx_valid 4 cycles after last sclk rise.
//  Frame 0x8001 with rx_ready held low, then frame 0x1234
//   -> rx_word stays 0x8001; overrun=1 after second frame.
//   -> Assert rx_ready: valid drops; no 0x1234.
//  sync raised after 7 of 16 bits -> frame_err pulses once, rx_valid stays 0.
//   Next full frame 0xFFFF is received correctly.
//  sync low at reset release, 16 clocks, sync high, then valid frame 0x0F0F
//   -> only 0x0F0F delivered, no frame_err.
//  rst asserted mid-frame (bit 9) -> all outputs 0 next cycle.
//   The following frame 0xC3C3 is received.
//  Back-to-back frames 0x0001, 0x0002 with rx_ready=1, sync high 2 sclk periods
//   -> both delivered in order, overrun=0.

Source files
------------

// File: rtl/dac_serial_pkg.sv
// Shared definitions for the DAC serial link (transmitter and receiver sides).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dac_serial_pkg;

    // Bits per serial frame, common to dac_controller and dac_frame_receiver
    localparam int DAC_FRAME_BITS = 16;

    // Receiver framing state
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        RX        = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings one asynchronous pin into clk and flags its rising/falling edges.
// Latency: level follows the pin after SYNC_STAGES clk edges; rise/fall are combinational on level.
// Backpressure: none; edges are single-cycle strobes.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the pin through the synchroniser and remember last synced level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-history flops, reset to the pin's idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac_frame_receiver.sv
// Deserialises MSB-first frames from the 3-wire DAC link (sclk, active-low sync, data).
// Latency: last sclk pin rise -> rx_valid high in SYNC_STAGES+2 clk cycles.
// Backpressure: one-word output register; a word arriving while it is still held is dropped and overrun sets.
module dac_frame_receiver
    import dac_serial_pkg::*;
#(
    parameter int FRAME_BITS  = DAC_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ser_clk,
    input  logic                  ser_sync,
    input  logic                  ser_data,
    output logic [FRAME_BITS-1:0] rx_word,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int                CNT_W       = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST_M1 = CNT_W'(FRAME_BITS - 1);
    localparam int                SETTLE_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

    logic sclk_lvl, clk_rise, sclk_fall_unused;
    logic sync_lvl, sync_rise, sync_fall;
    logic data_lvl, data_rise_unused, data_fall_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ser_clk),
        .level (sclk_lvl),
        .rise  (clk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ser_sync),
        .level (sync_lvl),
        .rise  (sync_rise),
        .fall  (sync_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ser_data),
        .level (data_lvl),
        .rise  (data_rise_unused),
        .fall  (data_fall_unused)
    );

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    deliver_q, deliver_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [FRAME_BITS-1:0]   rx_word_q, rx_word_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    overrun_q, overrun_d;

    // Framing FSM: counts synced sclk rises inside a sync-low window.
    // The synced sync level reads its reset value (high) until the chain has
    // flushed, so WAIT_IDLE also waits for the chain to settle; otherwise a
    // frame already running at reset release would look like a fresh start.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;
        settle_d    = (settle_q == SETTLE_DONE) ? settle_q : settle_q + SETTLE_W'(1);
        case (state_q)
            WAIT_IDLE: begin
                if ((settle_q == SETTLE_DONE) && sync_lvl) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (sync_fall) begin
                    state_d   = RX;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            RX: begin
                // sync_rise wins over a coincident clk_rise: that bit is not taken
                if (sync_rise) begin
                    frame_err_d = (bit_cnt_q != '0);
                    state_d     = IDLE;
                end else if (clk_rise && (bit_cnt_q != CNT_LAST)) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], data_lvl};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_LAST_M1) begin
                        deliver_d = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
        busy_d = (state_d == RX);
    end

    // Output register: load a finished word if the slot is free or being drained this cycle
    always_comb begin
        rx_word_d  = rx_word_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_word_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // All receiver state; reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            settle_q    <= '0;
            rx_word_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            settle_q    <= settle_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_word   = rx_word_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
